mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu.sv | 162 ++++++++++++++++
 tb/tb_mdu.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states,
// and latency-counter sizing.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int CNT_W = 6;

    // Multiplies and divides occupy the unit for several cycles; the rest do not.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO result registers. Results are
// computed combinationally from latched operands; a counter models the latency.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic             write;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
    } div_res_t;

    // Divide-by-zero suppresses the write; most-negative / -1 is pinned
    // rather than relying on the host division overflow behaviour.
    function automatic div_res_t div_calc(input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y,
                                          input logic             signed_op);
        div_res_t         res;
        logic signed [WIDTH-1:0] sx;
        logic signed [WIDTH-1:0] sy;
        sx        = x;
        sy        = y;
        res.write = 1'b1;
        res.quo   = '0;
        res.rem   = '0;
        if (y == '0) begin
            res.write = 1'b0;
        end else if (signed_op) begin
            if ((x == MOST_NEG) && (y == '1)) begin
                res.quo = MOST_NEG;
                res.rem = '0;
            end else begin
                res.quo = sx / sy;
                res.rem = sx % sy;
            end
        end else begin
            res.quo = x / y;
            res.rem = x % y;
        end
        return res;
    endfunction

    state_e             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               busy_next;
    logic [WIDTH-1:0]   hi_next, lo_next;
    logic               load;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   op_a, op_b;

    logic [2*WIDTH-1:0] ext_a, ext_b, product;
    div_res_t           div_res;

    // One 2W-bit multiplier serves both forms: extension choice sets signedness.
    always_comb begin
        if (op_q == OP_MULT) begin
            ext_a = {{WIDTH{op_a[WIDTH-1]}}, op_a};
            ext_b = {{WIDTH{op_b[WIDTH-1]}}, op_b};
        end else begin
            ext_a = {{WIDTH{1'b0}}, op_a};
            ext_b = {{WIDTH{1'b0}}, op_b};
        end
        product = ext_a * ext_b;
        div_res = div_calc(op_a, op_b, op_q == OP_DIV);
    end

    assign stall_req = busy | (start & is_long_op(md_op));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy_next  = busy;
        hi_next    = hi;
        lo_next    = lo;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_long_op(md_op)) begin
                        load       = 1'b1;
                        state_next = S_RUN;
                        busy_next  = 1'b1;
                        cnt_next   = is_mul_op(md_op) ? MUL_LAT : DIV_LAT;
                    end else if (md_op == OP_MTHI) begin
                        hi_next = a;
                    end else if (md_op == OP_MTLO) begin
                        lo_next = a;
                    end
                end
            end
            S_RUN: begin
                if (cnt == CNT_ONE) begin
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                    cnt_next   = '0;
                    if (is_mul_op(op_q)) begin
                        hi_next = product[2*WIDTH-1:WIDTH];
                        lo_next = product[WIDTH-1:0];
                    end else if (div_res.write) begin
                        hi_next = div_res.rem;
                        lo_next = div_res.quo;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= busy_next;
            hi    <= hi_next;
            lo    <= lo_next;
        end
    end

    // Operand latches hold data only; a stale value is harmless once reset
    // returns the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (load) begin
            op_q <= md_op;
            op_a <= a;
            op_b <= b;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, HI/LO results, MTHI/MTLO, ignored starts,
// divide special cases and mid-operation reset.
module tb_mdu;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int n;

    mdu dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .md_op    (md_op),
        .a        (op_a),
        .b        (op_b),
        .busy     (busy),
        .stall_req(stall_req),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start cycle, check stall_req during it, then scramble operands.
    task automatic go(input string tag, input logic [2:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic stall_exp);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        op_a  = x;
        op_b  = y;
        #1;
        check({tag, "_stall"}, {31'd0, stall_req}, {31'd0, stall_exp});
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd6;
        op_a  = 32'hDEAD_BEEF;
        op_b  = 32'h0BAD_F00D;
    endtask

    // Count remaining busy cycles, bounded so a stuck busy cannot hang the run.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        md_op   = 3'd0;
        op_a    = '0;
        op_b    = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // MULT -2 * 3
        go("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_done(n);
        check("mult_lat", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFF * 2
        go("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_done(n);
        check("multu_lat", n, 32'd5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // DIV -7 / 2
        go("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(n);
        check("div_lat", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 7 / 0 leaves HI/LO untouched
        go("divz", 3'd3, 32'd7, 32'd0, 1'b1);
        wait_done(n);
        check("divz_lat", n, 32'd10);
        check("divz_hi", hi, 32'hFFFF_FFFF);
        check("divz_lo", lo, 32'hFFFF_FFFD);

        // DIV 7 / -2
        go("divn", 3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done(n);
        check("divn_lo", lo, 32'hFFFF_FFFD);
        check("divn_hi", hi, 32'd1);

        // DIVU 100 / 7
        go("divu", 3'd3, 32'd100, 32'd7, 1'b1);
        wait_done(n);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // DIV most-negative / -1
        go("divov", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(n);
        check("divov_lo", lo, 32'h8000_0000);
        check("divov_hi", hi, 32'd0);

        // MTHI / MTLO in IDLE
        go("mthi", 3'd4, 32'h0000_1234, 32'd0, 1'b0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo", lo, 32'h8000_0000);
        go("mtlo", 3'd5, 32'h0000_ABCD, 32'd0, 1'b0);
        check("mtlo_lo", lo, 32'h0000_ABCD);
        check("mtlo_hi", hi, 32'h0000_1234);

        // no-op codes change nothing
        go("nop6", 3'd6, 32'd99, 32'd99, 1'b0);
        go("nop7", 3'd7, 32'd77, 32'd77, 1'b0);
        check("nop_busy", {31'd0, busy}, 32'd0);
        check("nop_hi", hi, 32'h0000_1234);
        check("nop_lo", lo, 32'h0000_ABCD);

        // MTLO while a MULT is in flight is ignored
        go("mulb", 3'd0, 32'd7, 32'd6, 1'b1);
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd5;
        op_a  = 32'd5;
        #1;
        check("mtlo_busy_stall", {31'd0, stall_req}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd6;
        wait_done(n);
        check("mulb_rem_lat", n, 32'd3);
        check("mulb_lo", lo, 32'd42);
        check("mulb_hi", hi, 32'd0);

        // Reset in cycle 3 of a DIV aborts it
        go("mthi2", 3'd4, 32'h0000_0055, 32'd0, 1'b0);
        go("divr", 3'd2, 32'd100, 32'd3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_hi", hi, 32'd0);
        check("post_lo", lo, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
